yarp_fetch_unit: RTL and testbench
==================================

Name: yarp_fetch_unit

Overview:
- Front-end fetch stage; sits directly upstream of the instruction-memory stage.
- Owns the program counter and issues in-order read requests (req/gnt, then rvalid) to instruction memory.
- Buffers returned instructions, tagged with their PC, in a small prefetch FIFO that feeds decode through a valid/ready handshake.
- Redirects (branch, jump, trap) flush the FIFO and discard any responses still in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, minimum 2; also the cap on buffered + outstanding requests.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- redirect_valid_i  input  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored and treated as 0
- fetch_req_o  output  1  read request to instruction memory
- fetch_addr_o  output  32  request address, equal to the current PC
- fetch_gnt_i  input  1  memory accepts the request this cycle
- fetch_rvalid_i  input  1  read data valid; responses return in issue order, at least 1 cycle after grant
- fetch_rdata_i  input  32  returned instruction word
- instr_valid_o  output  1  FIFO head valid
- instr_o  output  32  FIFO head instruction
- instr_pc_o  output  32  PC of the FIFO head instruction
- instr_ready_i  input  1  decode consumes the head when instr_valid_o is 1

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset:
  - pc = RESET_PC, resp_pc = RESET_PC.
  - FIFO empty; outstanding = 0; drop_cnt = 0.
  - fetch_req_o = 0 and instr_valid_o = 0 during every cycle in which reset is high.
- Counter width: outstanding and drop_cnt are $clog2(FIFO_DEPTH)+1 bits.
- Request issue:
  - fetch_req_o = !reset && !redirect_valid_i && (fifo_count + outstanding < FIFO_DEPTH).
  - The credit check guarantees no FIFO overflow.
  - fetch_addr_o = pc.
  - Issue occurs on fetch_req_o && fetch_gnt_i: pc <= pc + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), outstanding increments.
  - fetch_req_o may stay asserted across cycles; the address changes only after a grant.
- Response handling (in fetch_rvalid_i cycles; outstanding decrements in every case):
  - If drop_cnt > 0: the response is discarded and drop_cnt decrements.
  - Otherwise: push {fetch_rdata_i, resp_pc} into the FIFO, then resp_pc <= resp_pc + 4.
  - fetch_rvalid_i while outstanding == 0 is illegal (assertion); behaviour is undefined.
- Output:
  - instr_valid_o = FIFO non-empty; instr_o and instr_pc_o come from the head entry.
  - Pop on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle leave the count unchanged; a push into a full FIFO cannot occur.
  - instr_o and instr_pc_o hold stable while instr_valid_o = 1 and instr_ready_i = 0.
- Redirect (redirect_valid_i = 1) takes priority over all other updates in that cycle:
  - pc <= redirect_pc_i & ~3; resp_pc <= the same value.
  - FIFO cleared; any pop in that cycle is ignored.
  - A response arriving that cycle is discarded.
  - drop_cnt <= outstanding - fetch_rvalid_i.
  - No request issues in the redirect cycle.
  - Back-to-back redirects: the last one wins, and drop_cnt recomputes each time.
  - Requests may issue during drop (the cycle after a redirect onward); their responses arrive after all dropped ones and are kept.
- Latency:
  - Redirect to first fetch_req_o: 1 cycle.
  - rvalid to instr_valid_o: 1 cycle (without the optional feature).
- Reset mid-operation: returns all state to reset values on the next edge; in-flight responses arriving after reset deasserts while outstanding == 0 are ignored.
- Steady-state throughput: 1 instruction/cycle with single-cycle memory and decode always ready.

Optional Feature:
- Macro: YARP_FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop_cnt == 0, no redirect, and fetch_rvalid_i = 1:
  - instr_valid_o, instr_o and instr_pc_o are driven combinationally from fetch_rdata_i and resp_pc.
  - If instr_ready_i = 1, the word is consumed without being pushed (0-cycle latency).
  - Otherwise it is pushed as normal.
- Not defined: all outputs are sourced from FIFO registers only (1-cycle rvalid-to-valid latency).

Test Plan:
- Reset release; memory grants every cycle with rvalid 1 cycle later; decode ready -> addresses 0x0, 0x4, 0x8...; instr_pc_o 0x0, 0x4, 0x8 in order; 1 instr/cycle after fill.
- Decode stalls with instr_ready_i = 0 and FIFO_DEPTH = 4 -> exactly 4 grants accepted; fetch_req_o drops to 0; instr_o and instr_pc_o stable; resumes 1 cycle after ready returns.
- 2 requests outstanding, then redirect to 0x100 -> next 2 rvalids discarded; FIFO empty; next fetch_addr_o = 0x100; first delivered instr_pc_o = 0x100.
- Redirect to 0x203 -> fetch_addr_o = 0x200; redirect asserted in the same cycle as an rvalid and a pop -> FIFO empty and that response discarded.
- Memory withholds fetch_gnt_i for 3 cycles -> fetch_addr_o held at 0x8 with fetch_req_o = 1; pc advances only on grant.
- Reset asserted mid-stream with 3 entries buffered -> next cycle instr_valid_o = 0 and fetch_addr_o = RESET_PC; fetch restarts cleanly.

Source files
------------

// File: rtl/yarp_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order instruction reads and buffers tagged words for decode.
// Define YARP_FETCH_BYPASS_EN to forward a returning word straight to decode when the FIFO is empty.
module yarp_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_gnt_i,
    input  logic        fetch_rvalid_i,
    input  logic [31:0] fetch_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_instr [FIFO_DEPTH];
    logic [31:0]   r_mem_pc    [FIFO_DEPTH];

    logic          w_rsp;
    logic          w_keep;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_fifo_valid;
    logic [SW-1:0] w_inflight;
    logic [31:0]   w_redirect_pc;

    // Credit covers both buffered words and requests whose data is still in flight.
    assign w_inflight    = SW'(r_count) + SW'(r_outstanding);
    assign fetch_req_o   = !reset && !redirect_valid_i && (w_inflight < SW'(FIFO_DEPTH));
    assign fetch_addr_o  = r_pc;
    assign w_issue       = fetch_req_o && fetch_gnt_i;
    assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};

    // Stray rvalid with nothing outstanding (e.g. a pre-reset response) is ignored.
    assign w_rsp        = fetch_rvalid_i && (r_outstanding != '0);
    assign w_keep       = w_rsp && (r_drop_cnt == '0) && !redirect_valid_i;
    assign w_fifo_valid = (r_count != '0);
    assign w_pop        = !reset && !redirect_valid_i && w_fifo_valid && instr_ready_i;

`ifdef YARP_FETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass      = w_keep && !w_fifo_valid;
    assign instr_valid_o = !reset && (w_fifo_valid || w_bypass);
    assign instr_o       = w_bypass ? fetch_rdata_i : r_mem_instr[r_rd_ptr];
    assign instr_pc_o    = w_bypass ? r_resp_pc     : r_mem_pc[r_rd_ptr];
    assign w_push        = w_keep && !(w_bypass && instr_ready_i);
`else
    assign instr_valid_o = !reset && w_fifo_valid;
    assign instr_o       = r_mem_instr[r_rd_ptr];
    assign instr_pc_o    = r_mem_pc[r_rd_ptr];
    assign w_push        = w_keep;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else if (redirect_valid_i) begin
            // Everything still in flight after this edge belongs to the old path.
            r_pc          <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_outstanding <= r_outstanding - CW'(w_rsp);
            r_drop_cnt    <= r_outstanding - CW'(w_rsp);
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_keep) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
            if (w_rsp && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_rsp);
            r_count       <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem_instr[r_wr_ptr] <= fetch_rdata_i;
            r_mem_pc[r_wr_ptr]    <= r_resp_pc;
        end
    end

    a_rvalid_has_request: assert property (
        @(posedge clk) disable iff (reset) fetch_rvalid_i |-> (r_outstanding != '0)
    );

endmodule

// File: tb/tb_yarp_fetch_unit.sv
// Randomized bench for yarp_fetch_unit: in-order memory model plus a queue-based fetch reference.
module tb_yarp_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_req_o;
    logic [31:0] fetch_addr_o;
    logic        fetch_gnt_i;
    logic        fetch_rvalid_i;
    logic [31:0] fetch_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    yarp_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .fetch_req_o      (fetch_req_o),
        .fetch_addr_o     (fetch_addr_o),
        .fetch_gnt_i      (fetch_gnt_i),
        .fetch_rvalid_i   (fetch_rvalid_i),
        .fetch_rdata_i    (fetch_rdata_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
    typedef struct packed { logic [31:0] addr; int due; } req_t;

    ent_t        mq[$];     // words decode has yet to see, oldest first
    req_t        pend[$];   // granted requests awaiting data, in issue order
    logic [31:0] m_pc;
    logic [31:0] m_rpc;
    int          m_drop;
    int          cyc;
    int          npop;
    int          total;
    int          bad;
    int          p_gnt;
    int          p_ready;
    int          p_rv;
    int          p_redir;
    int          max_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic rst, input logic redir, input logic [31:0] tgt);
        logic        rv;
        logic        byp;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        req_t        r;
        @(negedge clk);
        rv = 1'b0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < p_rv) rv = 1'b1;
        reset            = rst;
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        fetch_gnt_i      = ($urandom_range(99) < p_gnt);
        instr_ready_i    = ($urandom_range(99) < p_ready);
        fetch_rvalid_i   = rv;
        fetch_rdata_i    = rv ? mem_word(pend[0].addr) : $urandom();

        exp_req   = !rst && !redir && (mq.size() + pend.size() < DEPTH);
        exp_valid = !rst && mq.size() > 0;
        exp_instr = exp_valid ? mq[0].instr : 32'h0;
        exp_pc    = exp_valid ? mq[0].pc : 32'h0;
        byp = 1'b0;
`ifdef YARP_FETCH_BYPASS_EN
        byp = !rst && !redir && mq.size() == 0 && m_drop == 0 && rv;
        if (byp) begin
            exp_valid = 1'b1;
            exp_instr = fetch_rdata_i;
            exp_pc    = m_rpc;
        end
`endif
        #1;
        check_eq("req", 32'(fetch_req_o), 32'(exp_req));
        if (!rst) check_eq("addr", fetch_addr_o, m_pc);
        check_eq("valid", 32'(instr_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("instr", instr_o, exp_instr);
            check_eq("instr_pc", instr_pc_o, exp_pc);
        end

        if (rst) begin
            m_pc = RESET_PC; m_rpc = RESET_PC; m_drop = 0;
            mq.delete(); pend.delete();
        end else if (redir) begin
            if (rv) void'(pend.pop_front());
            m_drop = pend.size();
            m_pc   = tgt & ~32'h3;
            m_rpc  = tgt & ~32'h3;
            mq.delete();
        end else begin
            if (exp_valid && instr_ready_i) npop++;
            if (!byp && exp_valid && instr_ready_i) void'(mq.pop_front());
            if (rv) begin
                void'(pend.pop_front());
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    if (!(byp && instr_ready_i)) mq.push_back({fetch_rdata_i, m_rpc});
                    m_rpc = m_rpc + 32'd4;
                end
            end
            if (exp_req && fetch_gnt_i) begin
                r.addr = m_pc;
                r.due  = cyc + 1 + $urandom_range(max_lat - 1);
                pend.push_back(r);
                m_pc = m_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
    endtask

    task automatic run_rand(input int n);
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
            step(1'b0, $urandom_range(99) < p_redir, tgt);
        end
    endtask

    initial begin
        reset = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        fetch_gnt_i = 1'b0; fetch_rvalid_i = 1'b0; fetch_rdata_i = '0; instr_ready_i = 1'b0;
        m_pc = RESET_PC; m_rpc = RESET_PC; m_drop = 0;
        cyc = 0; npop = 0; total = 0; bad = 0;
        p_gnt = 100; p_ready = 100; p_rv = 100; p_redir = 0; max_lat = 1;

        repeat (3) step(1'b1, 1'b0, 32'h0);

        // Single-cycle memory, decode always ready: one instruction per cycle once filled.
        run(10);
        npop = 0;
        run(40);
        check_eq("throughput", 32'(npop), 32'd40);

        // Decode stall fills the FIFO and throttles requests.
        p_ready = 0;
        run(12);
        check_eq("stall_req", 32'(fetch_req_o), 32'd0);
        p_ready = 100;
        run(6);

        // Memory withholds grants; address must hold.
        p_gnt = 0;
        run(3);
        p_gnt = 100;
        run(4);

        // Redirect with requests outstanding and no data back yet.
        p_rv = 0;
        run(2);
        step(1'b0, 1'b1, 32'h0000_0100);
        p_rv = 100;
        run(10);

        // Unaligned target, then redirect colliding with an rvalid and a pop.
        step(1'b0, 1'b1, 32'h0000_0203);
        run(6);
        step(1'b0, 1'b1, 32'h0000_0400);
        step(1'b0, 1'b1, 32'hFFFF_FFF4);
        run(8);

        // Reset mid-stream with entries buffered.
        p_ready = 0;
        run(6);
        step(1'b1, 1'b0, 32'h0);
        p_ready = 100;
        run(8);

        // Random traffic with variable latency, grants, stalls and redirects.
        p_gnt = 70; p_ready = 60; p_rv = 80; p_redir = 5; max_lat = 3;
        run_rand(3000);
        p_redir = 0; p_ready = 100; p_rv = 100; p_gnt = 100;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
